// File: rtl/pipe_stage_reg_if.sv
// Valid/ready word bus between pipeline stages: control field, destination register and payload.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [RD_W-1:0]   rd;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output rd,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  rd,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, bubble-zeroed control and flush.
// Define PIPE_REG_SKID_EN to add a second (skid) entry and make the upstream ready a register.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5,
  parameter int DATA_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [1:0]       occupancy
);

  logic              accept;
  logic              rel;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [RD_W-1:0]   main_rd_q,    main_rd_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;

  assign accept    = up.valid & up.ready;
  assign rel       = main_valid_q & dn.ready;

  // Control and rd are cleared whenever the main entry empties, so they are NOPs when invalid.
  assign dn.valid  = main_valid_q;
  assign dn.ctrl   = main_ctrl_q;
  assign dn.rd     = main_rd_q;
  assign dn.data   = main_data_q;

`ifdef PIPE_REG_SKID_EN

  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [RD_W-1:0]   skid_rd_q,    skid_rd_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;

  assign up.ready  = in_ready_q & ~flush;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_rd_d    = main_rd_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_rd_d    = '0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_rd_d    = '0;
      skid_data_d  = '0;
    end else if (rel) begin
      if (skid_valid_q) begin
        // Upstream is blocked while the skid is full, so no accept can coincide here.
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_rd_d    = skid_rd_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
        skid_rd_d    = '0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = up.ctrl;
        main_rd_d    = up.rd;
        main_data_d  = up.data;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
        main_rd_d    = '0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = up.ctrl;
        skid_rd_d    = up.rd;
        skid_data_d  = up.data;
      end else begin
        main_valid_d = 1'b1;
        main_ctrl_d  = up.ctrl;
        main_rd_d    = up.rd;
        main_data_d  = up.data;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

`else

  // Single entry: room exists when empty or when the held word leaves this cycle.
  assign up.ready  = reset & ~flush & (~main_valid_q | dn.ready);
  assign occupancy = {1'b0, main_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_rd_d    = main_rd_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_rd_d    = '0;
      main_data_d  = '0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = up.ctrl;
      main_rd_d    = up.rd;
      main_data_d  = up.data;
    end else if (rel) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_rd_d    = '0;
    end
  end

`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_rd_q    <= '0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_rd_q    <= main_rd_d;
      main_data_q  <= main_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random valid/ready traffic,
// compared against a queue-based model of the stage (PIPE_REG_SKID_EN selects depth 2).
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [63:0] data;
  } word_t;

`ifdef PIPE_REG_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk;
  logic       reset_s;
  logic       flush;
  logic [1:0] occupancy;

  pipe_stage_reg_if #(.CTRL_W(4), .RD_W(5), .DATA_W(64)) up_if ();
  pipe_stage_reg_if #(.CTRL_W(4), .RD_W(5), .DATA_W(64)) dn_if ();

  pipe_stage_reg #(.CTRL_W(4), .RD_W(5), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset_s),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          errors = 0;
  int          checks = 0;
  word_t       q[$];
  logic [63:0] hold_data = '0;
  logic        rdy_reg   = 1'b0;
  logic        exp_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold_data = '0;
    rdy_reg   = 1'b0;
  endtask

  // Full comparison of every output against the model; call away from the clock edge.
  task automatic check_all(input string tag);
    int n;
    n = q.size();
`ifdef PIPE_REG_SKID_EN
    exp_rdy = rdy_reg & ~flush;
`else
    exp_rdy = reset_s & ~flush & ((n == 0) | dn_if.ready);
`endif
    chk({tag, ".in_ready"},  64'(up_if.ready),  64'(exp_rdy));
    chk({tag, ".out_valid"}, 64'(dn_if.valid),  64'(n > 0));
    chk({tag, ".out_ctrl"},  64'(dn_if.ctrl),   (n > 0) ? 64'(q[0].ctrl) : 64'd0);
    chk({tag, ".out_rd"},    64'(dn_if.rd),     (n > 0) ? 64'(q[0].rd) : 64'd0);
    chk({tag, ".out_data"},  dn_if.data,        (n > 0) ? q[0].data : hold_data);
    chk({tag, ".occupancy"}, 64'(occupancy),    64'(n));
  endtask

  task automatic cycle(input string tag, input logic v, input logic [3:0] c, input logic [4:0] r,
                       input logic [63:0] d, input logic ordy, input logic fl);
    logic  acc, rel;
    word_t w;
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.rd    = r;
    up_if.data  = d;
    dn_if.ready = ordy;
    flush       = fl;
    @(negedge clk);
    check_all(tag);
    acc = v & exp_rdy;
    rel = (q.size() > 0) & ordy;
    w   = '{ctrl: c, rd: r, data: d};
    @(posedge clk);
    if (fl) begin
      q.delete();
      hold_data = '0;
    end else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    if (q.size() > 0) hold_data = q[0].data;
    rdy_reg = (q.size() < 2);
    #1;
  endtask

  initial begin
    reset_s     = 1'b0;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    up_if.ctrl  = '0;
    up_if.rd    = '0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    model_reset();
    #1;
    chk("por.out_valid", 64'(dn_if.valid), 64'd0);
    chk("por.in_ready",  64'(up_if.ready), 64'd0);
    chk("por.occupancy", 64'(occupancy),   64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_s = 1'b1;

    // Single word then drain: control/rd zeroed, payload held.
    cycle("t2a", 1'b1, 4'b0110, 5'd5, 64'hA5, 1'b1, 1'b0);
    chk("t2.valid", 64'(dn_if.valid), 64'd1);
    chk("t2.ctrl",  64'(dn_if.ctrl),  64'b0110);
    chk("t2.rd",    64'(dn_if.rd),    64'd5);
    chk("t2.data",  dn_if.data,       64'hA5);
    cycle("t2b", 1'b0, 4'b0000, 5'd0, 64'h0, 1'b1, 1'b0);
    chk("t2.drain_valid", 64'(dn_if.valid), 64'd0);
    chk("t2.drain_ctrl",  64'(dn_if.ctrl),  64'd0);
    chk("t2.drain_rd",    64'(dn_if.rd),    64'd0);
    chk("t2.drain_data",  dn_if.data,       64'hA5);

    // Stall with 0x11 held while 0x22 is offered.
    cycle("t3a", 1'b1, 4'b1001, 5'd3, 64'h11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("t3s", 1'b1, 4'b0011, 5'd7, 64'h22, 1'b0, 1'b0);
      chk("t3.stall_data", dn_if.data,      64'h11);
      chk("t3.stall_ctrl", 64'(dn_if.ctrl), 64'b1001);
    end
    cycle("t3r", 1'b1, 4'b0011, 5'd7, 64'h22, 1'b1, 1'b0);
    chk("t3.second_data", dn_if.data,     64'h22);
    chk("t3.second_rd",   64'(dn_if.rd),  64'd7);
    cycle("t3d", 1'b0, 4'b0000, 5'd0, 64'h0, 1'b1, 1'b0);
    chk("t3.empty", 64'(dn_if.valid), 64'd0);

    // Back-to-back stream, no bubbles.
    for (int k = 1; k <= 4; k++) begin
      cycle("t4", 1'b1, 4'b0001, 5'(k), 64'(k), 1'b1, 1'b0);
      chk("t4.valid", 64'(dn_if.valid), 64'd1);
      chk("t4.data",  dn_if.data,       64'(k));
    end

    // Asynchronous reset mid-stream while out_valid=1.
    reset_s = 1'b0;
    model_reset();
    #1;
    chk("t1.out_valid", 64'(dn_if.valid), 64'd0);
    chk("t1.out_ctrl",  64'(dn_if.ctrl),  64'd0);
    chk("t1.out_rd",    64'(dn_if.rd),    64'd0);
    chk("t1.out_data",  dn_if.data,       64'd0);
    chk("t1.occupancy", 64'(occupancy),   64'd0);
    chk("t1.in_ready",  64'(up_if.ready), 64'd0);
    @(posedge clk);
    #1;
    reset_s = 1'b1;
    cycle("t1r", 1'b0, 4'b0000, 5'd0, 64'h0, 1'b0, 1'b0);

    // Fill under stall, then flush with a word offered in the flush cycle.
    cycle("t5a", 1'b1, 4'b1111, 5'd9, 64'h33, 1'b0, 1'b0);
    cycle("t5b", 1'b1, 4'b1110, 5'd10, 64'h44, 1'b0, 1'b0);
    chk("t5.occ_full", 64'(occupancy), 64'(DEPTH));
    cycle("t5f", 1'b1, 4'b1101, 5'd11, 64'h55, 1'b1, 1'b1);
    chk("t5.valid", 64'(dn_if.valid), 64'd0);
    chk("t5.occ",   64'(occupancy),   64'd0);
    chk("t5.ctrl",  64'(dn_if.ctrl),  64'd0);
    chk("t5.data",  dn_if.data,       64'd0);
    cycle("t5n", 1'b0, 4'b0000, 5'd0, 64'h0, 1'b1, 1'b0);

    // Random traffic against the model, occasional flush.
    for (int i = 0; i < 10000; i++) begin
      cycle("rnd", 1'($urandom_range(1)), 4'($urandom_range(15)), 5'($urandom_range(31)),
            {$urandom(), $urandom()}, 1'($urandom_range(3) != 0), 1'($urandom_range(63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
